// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 constants: register numbers, exception codes, bit-field positions.
package cp0_exc_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned INT_W  = 6;

  localparam logic [DATA_W-1:0] PRID_DEFAULT    = 32'h2021_0007;
  localparam logic [DATA_W-1:0] EXC_VEC_DEFAULT = 32'h0000_4180;

  // CP0 register numbers
  localparam logic [ADDR_W-1:0] REG_SR    = 5'd12;
  localparam logic [ADDR_W-1:0] REG_CAUSE = 5'd13;
  localparam logic [ADDR_W-1:0] REG_EPC   = 5'd14;
  localparam logic [ADDR_W-1:0] REG_PRID  = 5'd15;

  // ExcCode values
  typedef enum logic [CODE_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // SR bit fields
  localparam int unsigned SR_IE_BIT  = 0;
  localparam int unsigned SR_EXL_BIT = 1;
  localparam int unsigned SR_IM_LSB  = 10;

  // Cause bit fields
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  localparam logic [DATA_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Return address saved for the victim: word-aligned PC, minus 4 if in a delay slot
  function automatic logic [DATA_W-1:0] victim_epc(input logic [DATA_W-1:0] pc,
                                                   input logic              bd);
    logic [DATA_W-1:0] pc_al;
    pc_al = pc & WORD_ALIGN_MASK;
    return bd ? (pc_al - 32'd4) : pc_al;
  endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller: SR/Cause/EPC/PRId, arbitration and flush request.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID    = PRID_DEFAULT,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              bd_in,
  input  logic [CODE_W-1:0] exc_code_in,
  input  logic [INT_W-1:0]  hw_int,
  input  logic              eret,
  output logic              req,
  output logic [DATA_W-1:0] epc_out,
  output logic [DATA_W-1:0] exc_vec
);

  logic [INT_W-1:0]  sr_im;
  logic              sr_exl;
  logic              sr_ie;
  logic              cause_bd;
  logic [INT_W-1:0]  cause_ip;
  logic [CODE_W-1:0] cause_exc;
  logic [DATA_W-1:0] epc;

  logic              int_req;
  logic              exc_req;
  logic [CODE_W-1:0] code_sel;
  logic              wr_sr;
  logic              wr_epc;
  logic              wr_epc_any;
  logic [DATA_W-1:0] wdata_al;
  logic [DATA_W-1:0] sr_word;
  logic [DATA_W-1:0] cause_word;

  // Arbitration: interrupts beat exceptions, EXL masks everything
  always_comb begin
    int_req  = sr_ie & ~sr_exl & (|(hw_int & sr_im));
    exc_req  = (exc_code_in != CODE_W'(0)) & ~sr_exl;
    req      = int_req | exc_req;
    code_sel = int_req ? CODE_W'(EXC_INT) : exc_code_in;
  end

  // mtc0 decode; a flush request drops the write
  always_comb begin
    wdata_al   = wdata & WORD_ALIGN_MASK;
    wr_epc_any = we & (addr == REG_EPC);
    wr_sr      = we & ~req & (addr == REG_SR);
    wr_epc     = wr_epc_any & ~req;
  end

  // Pack architectural fields into their register words
  always_comb begin
    sr_word                              = '0;
    sr_word[SR_IM_LSB +: INT_W]          = sr_im;
    sr_word[SR_EXL_BIT]                  = sr_exl;
    sr_word[SR_IE_BIT]                   = sr_ie;
    cause_word                           = '0;
    cause_word[CAUSE_BD_BIT]             = cause_bd;
    cause_word[CAUSE_IP_LSB +: INT_W]    = cause_ip;
    cause_word[CAUSE_EXC_LSB +: CODE_W]  = cause_exc;
  end

  // mfc0 read mux, shows pre-write register values
  always_comb begin
    rdata = '0;
    case (addr)
      REG_SR:    rdata = sr_word;
      REG_CAUSE: rdata = cause_word;
      REG_EPC:   rdata = epc;
      REG_PRID:  rdata = PRID;
      default:   rdata = '0;
    endcase
  end

  // eret target, bypassing an mtc0 to EPC in the same cycle
  always_comb begin
    epc_out = wr_epc_any ? wdata_al : epc;
    exc_vec = EXC_VEC;
  end

  // CP0 register update: exception entry, eret and mtc0
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        cause_exc <= code_sel;
        epc       <= victim_epc(pc_in, bd_in);
      end else begin
        if (wr_sr) begin
          sr_im  <= wdata[SR_IM_LSB +: INT_W];
          sr_exl <= wdata[SR_EXL_BIT];
          sr_ie  <= wdata[SR_IE_BIT];
        end
        if (eret) begin
          sr_exl <= 1'b0;
        end
        if (wr_epc) begin
          epc <= wdata_al;
        end
      end
    end
  end

endmodule
